lcd_cmd_seq: RTL and testbench

//  Script-driven command sequencer sitting directly upstream of the LCD controller.

---
 rtl/lcd_cmd_seq.sv | 173 +++++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_seq.sv
// Script-driven command sequencer for the LCD controller: walks an 8-bit command ROM
// and issues each command under the controller's busy/done handshake.
module lcd_cmd_seq #(
   parameter int unsigned SCRIPT_AW = 6,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           script_q,
   output logic                 script_en,
   output logic [SCRIPT_AW-1:0] script_addr,
   input  logic                 busy,
   input  logic                 done,
   output logic [2:0]           cmd,
   output logic                 cmd_valid,
   output logic                 running,
   output logic                 finished,
   output logic                 error,
   output logic [7:0]           cmd_count
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);
   localparam logic [SCRIPT_AW-1:0] PcMax = {SCRIPT_AW{1'b1}};

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StLatch,
      StWaitRdy,
      StIssue,
      StHold,
      StWaitDone,
      StFinish,
      StError
   } state_e;

   state_e               state_q, state_d;
   logic [SCRIPT_AW-1:0] pc_q, pc_d;
   logic [2:0]           cur_cmd_q, cur_cmd_d;
   logic [3:0]           rep_q, rep_d;
   logic                 last_q, last_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [2:0]           cmd_q, cmd_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 script_en_q, script_en_d;
   logic                 cmd_valid_q, cmd_valid_d;
   logic                 running_q, running_d;
   logic                 finished_q, finished_d;
   logic                 error_q, error_d;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cur_cmd_d   = cur_cmd_q;
      rep_d       = rep_q;
      last_d      = last_q;
      tmo_d       = '0;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      finished_d  = finished_q;
      error_d     = error_q;

      unique case (state_q)
         StIdle, StFinish, StError: begin
            if (start) begin
               state_d    = StFetch;
               pc_d       = '0;
               cnt_d      = '0;
               finished_d = 1'b0;
               error_d    = 1'b0;
            end
         end
         StFetch: state_d = StLatch;
         StLatch: begin
            cur_cmd_d = script_q[2:0];
            rep_d     = script_q[6:3];
            last_d    = script_q[7];
            state_d   = StWaitRdy;
         end
         StWaitRdy: begin
            if (!busy) begin
               state_d = StIssue;
            end else if (tmo_q == TmoLast) begin
               state_d = StError;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StIssue: state_d = StHold;
         // Busy is not sampled here: the controller raises it one cycle late.
         StHold: begin
            if (cur_cmd_q == 3'd0) begin
               state_d = StWaitDone;
            end else if (rep_q != 4'd0) begin
               rep_d   = rep_q - 4'd1;
               state_d = StWaitRdy;
            end else if (last_q) begin
               state_d = StFinish;
            end else if (pc_q == PcMax) begin
               state_d = StError;
            end else begin
               pc_d    = pc_q + SCRIPT_AW'(1);
               state_d = StFetch;
            end
         end
         StWaitDone: begin
            if (done) begin
               state_d = StFinish;
            end else if (tmo_q == TmoLast) begin
               state_d = StError;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      if (state_d == StIssue) begin
         cmd_d = cur_cmd_q;
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
      if (state_d == StFinish) finished_d = 1'b1;
      if (state_d == StError)  error_d    = 1'b1;
      script_en_d = (state_d == StFetch);
      cmd_valid_d = (state_d == StIssue);
      running_d   = !(state_d inside {StIdle, StFinish, StError});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         cur_cmd_q   <= '0;
         rep_q       <= '0;
         last_q      <= 1'b0;
         tmo_q       <= '0;
         cmd_q       <= '0;
         cnt_q       <= '0;
         script_en_q <= 1'b0;
         cmd_valid_q <= 1'b0;
         running_q   <= 1'b0;
         finished_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cur_cmd_q   <= cur_cmd_d;
         rep_q       <= rep_d;
         last_q      <= last_d;
         tmo_q       <= tmo_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         script_en_q <= script_en_d;
         cmd_valid_q <= cmd_valid_d;
         running_q   <= running_d;
         finished_q  <= finished_d;
         error_q     <= error_d;
      end
   end

   assign script_en   = script_en_q;
   assign script_addr = pc_q;
   assign cmd         = cmd_q;
   assign cmd_valid   = cmd_valid_q;
   assign running     = running_q;
   assign finished    = finished_q;
   assign error       = error_q;
   assign cmd_count   = cnt_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq: a script-level model predicts the command stream
// and run outcome; a monitor checks every cmd_valid against the expected queue.
module tb_lcd_cmd_seq;
   localparam int AW    = 6;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    script_q = 8'h00;
   logic          script_en;
   logic [AW-1:0] script_addr;
   logic          busy, done;
   logic [2:0]    cmd;
   logic          cmd_valid, running, finished, error;
   logic [7:0]    cmd_count;

   lcd_cmd_seq #(.SCRIPT_AW(AW), .TIMEOUT(255)) dut (
      .clk(clk), .reset(reset), .start(start), .script_q(script_q),
      .script_en(script_en), .script_addr(script_addr), .busy(busy), .done(done),
      .cmd(cmd), .cmd_valid(cmd_valid), .running(running), .finished(finished),
      .error(error), .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [DEPTH];
   always @(posedge clk) if (script_en) script_q <= rom[script_addr];

   // Controller model: busy rises two cycles after cmd_valid, done follows a write.
   int   busy_len = 1, done_delay = 0, busy_cnt = 0, done_cnt = 0;
   bit   force_busy = 1'b0;
   logic busy_lag = 1'b0;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_lag <= 1'b0; busy_cnt <= 0; done_cnt <= 0;
      end else begin
         busy_lag <= cmd_valid;
         if (busy_lag) busy_cnt <= busy_len;
         else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
         if (cmd_valid && cmd == 3'd0 && done_delay != 0) done_cnt <= done_delay;
         else if (done_cnt != 0) done_cnt <= done_cnt - 1;
      end
   end
   assign busy = force_busy || (busy_cnt != 0);
   assign done = (done_cnt == 1);

   int         tests = 0, fails = 0;
   logic [2:0] exp_q [$];
   logic       busy_prev = 1'b0;
   longint     cyc = 0, last_valid = -100;

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      busy_prev <= busy;
      cyc       <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!reset && cmd_valid) begin
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_cmd: got cmd_valid with cmd=%0d, required none", cmd);
         end else begin
            check("cmd_value", cmd, exp_q.pop_front());
         end
         check("busy_prev_at_issue", busy_prev, 0);
         if (cyc - last_valid < 4) check("issue_spacing", cyc - last_valid, 4);
         last_valid = cyc;
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("running_after_start", running, 1);
      check("fetch_addr0", {script_en, script_addr}, {1'b1, 6'd0});
   endtask

   // Script-level prediction: expand repeats, stop on write/end flag/last address.
   task automatic run(input int blen, input int ddel, input bit mid_start);
      bit efin = 0, eerr = 0, stop = 0;
      int en = 0, pc = 0, guard = 0;
      logic [7:0] w;
      busy_len = blen; done_delay = ddel;
      while (!stop) begin
         w = rom[pc];
         if (w[2:0] == 3'd0) begin
            exp_q.push_back(3'd0); en++;
            if (ddel == 0) eerr = 1; else efin = 1;
            stop = 1;
         end else begin
            for (int k = 0; k <= int'(w[6:3]); k++) begin exp_q.push_back(w[2:0]); en++; end
            if (w[7]) begin efin = 1; stop = 1; end
            else if (pc == DEPTH - 1) begin eerr = 1; stop = 1; end
            else pc++;
         end
      end
      pulse_start();
      if (mid_start) begin
         repeat (5) @(negedge clk);
         start = 1'b1; @(negedge clk); start = 1'b0;
      end
      while (running && guard < 20000) begin @(negedge clk); guard++; end
      check("run_terminates", running, 0);
      check("finished", finished, efin);
      check("error", error, eerr);
      check("cmd_count", cmd_count, (en > 255) ? 255 : en);
      check("all_cmds_seen", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int n;
      logic [7:0] w;
      for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {script_en, script_addr, cmd, cmd_valid, running, finished, error, cmd_count}, 0);
      reset = 1'b0;

      rom[0] = 8'h0C; rom[1] = 8'h05; rom[2] = 8'h00;
      run(1, 70, 1'b1);

      // Busy stuck: FETCH + LATCH + 255 WAIT_RDY cycles of running.
      force_busy = 1'b1;
      pulse_start();
      n = 0;
      while (running && n < 1000) begin n++; @(negedge clk); end
      check("stuck_running_cycles", n, 257);
      check("stuck_error", error, 1);
      check("stuck_cmd_count", cmd_count, 0);
      force_busy = 1'b0;
      repeat (3) @(negedge clk);

      rom[0] = 8'h81; run(1, 50, 1'b0);
      rom[0] = 8'h13; rom[1] = 8'h00; run(10, 40, 1'b0);
      for (int i = 0; i < DEPTH; i++) rom[i] = 8'h01;
      run(1, 50, 1'b0);
      for (int i = 0; i < DEPTH; i++) rom[i] = 8'h79;
      run(1, 50, 1'b0);
      rom[0] = 8'h02; rom[1] = 8'h00; run(2, 0, 1'b0);

      // Reset while parked in WAIT_DONE; must not resume afterwards.
      rom[0] = 8'h00; done_delay = 0; exp_q.push_back(3'd0);
      pulse_start();
      repeat (30) @(negedge clk);
      check("pre_reset_running", running, 1);
      #2 reset = 1'b1;
      #1 check("async_reset_outputs",
               {script_en, script_addr, cmd, cmd_valid, running, finished, error, cmd_count}, 0);
      @(negedge clk); reset = 1'b0;
      exp_q.delete();
      repeat (10) @(negedge clk);
      check("no_resume", {running, script_en, cmd_valid, cmd_count}, 0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            w = 8'($urandom_range(0, 255));
            w[7] = ($urandom_range(0, 5) == 0);
            rom[i] = w;
         end
         run($urandom_range(1, 12), $urandom_range(2, 200), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
